pulse_width_decoder: RTL and testbench

- Receiving end of the button-triggered pulse controller: watches a single pulse line and measures how long each high pulse lasts.
- Width is counted in sample ticks, e.g. a slow counter bit used as a strobe.
- Reports each completed pulse once, with its width and a nominal/off-nominal classification, and flags pulses that stay high too long.
- Sits on the LED/pulse side of the board design; its outputs drive LEDs or downstream checking logic.

---
 rtl/pulse_width_decoder.sv | 146 ++++++++++++++
 tb/tb_pulse_width_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_width_decoder.sv
// Pulse width decoder: measures high pulses on din in tick units and classifies them.
// Optional PULSE_STATS_EN adds clr_stats/nom_cnt, a saturating nominal-report counter.
module pulse_width_decoder #(
   parameter int W       = 4,
   parameter int NOMINAL = 3,
   parameter int TOL     = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         tick,
   input  logic         din,
   output logic         valid,
   output logic [W-1:0] width,
   output logic         nominal,
   output logic         err_long,
`ifdef PULSE_STATS_EN
   input  logic         clr_stats,
   output logic [15:0]  nom_cnt,
`endif
   output logic [1:0]   state
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      MEAS   = 2'b01,
      REPORT = 2'b10,
      STUCK  = 2'b11
   } state_t;

   localparam logic [W-1:0] MAXW  = '1;
   localparam logic [W:0]   NOM_V = (W+1)'(NOMINAL);
   localparam logic [W:0]   TOL_V = (W+1)'(TOL);

   state_t       state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] width_q, width_d;
   logic         nominal_q, nominal_d;
   logic         err_q, err_d;
   logic         s1_q, ds_q;

   // One extra bit keeps the distance correct when cnt is below NOMINAL
   logic [W:0] cnt_ext;
   logic [W:0] diff;
   logic       nom_ok;

   assign cnt_ext = {1'b0, cnt_q};
   assign diff    = (cnt_ext >= NOM_V) ? cnt_ext - NOM_V : NOM_V - cnt_ext;
   assign nom_ok  = (diff <= TOL_V);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= 1'b0;
         ds_q <= 1'b0;
      end else begin
         s1_q <= din;
         ds_q <= s1_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      width_d   = width_q;
      nominal_d = nominal_q;
      err_d     = err_q;
      unique case (state_q)
         IDLE: begin
            if (tick && ds_q) begin
               state_d = MEAS;
               cnt_d   = W'(1);
            end
         end
         MEAS: begin
            if (tick) begin
               if (!ds_q) begin
                  state_d   = REPORT;
                  width_d   = cnt_q;
                  nominal_d = nom_ok;
               end else if (cnt_q == MAXW) begin
                  state_d = STUCK;
                  err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + W'(1);
               end
            end
         end
         REPORT: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         STUCK: begin
            if (tick && !ds_q) begin
               state_d = IDLE;
               err_d   = 1'b0;
               cnt_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         width_q   <= '0;
         nominal_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         width_q   <= width_d;
         nominal_q <= nominal_d;
         err_q     <= err_d;
      end
   end

   assign valid    = (state_q == REPORT);
   assign width    = width_q;
   assign nominal  = nominal_q;
   assign err_long = err_q;
   assign state    = state_q;

`ifdef PULSE_STATS_EN
   logic [15:0] nom_cnt_q, nom_cnt_d;

   always_comb begin
      nom_cnt_d = nom_cnt_q;
      if (clr_stats) begin
         nom_cnt_d = '0;
      end else if (valid && nominal_q && (nom_cnt_q != 16'hFFFF)) begin
         nom_cnt_d = nom_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nom_cnt_q <= '0;
      end else begin
         nom_cnt_q <= nom_cnt_d;
      end
   end

   assign nom_cnt = nom_cnt_q;
`endif

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Scoreboard bench for pulse_width_decoder (W=4, NOMINAL=3, TOL=0).
// Stats checks run only when PULSE_STATS_EN is defined.
module tb_pulse_width_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       din;
   logic       valid;
   logic [3:0] width;
   logic       nominal;
   logic       err_long;
   logic [1:0] state;
`ifdef PULSE_STATS_EN
   logic        clr_stats;
   logic [15:0] nom_cnt;
`endif

   typedef struct {
      logic [3:0] w;
      logic       n;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic prev_v = 1'b0;

   always #5 clk = ~clk;

   pulse_width_decoder #(.W(4), .NOMINAL(3), .TOL(0)) dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .din      (din),
      .valid    (valid),
      .width    (width),
      .nominal  (nominal),
      .err_long (err_long),
`ifdef PULSE_STATS_EN
      .clr_stats(clr_stats),
      .nom_cnt  (nom_cnt),
`endif
      .state    (state)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: every valid strobe must match the oldest expected report
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         exp_t e;
         if (prev_v) chk("valid_one_clk", 1, 0);
         if (sb.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("width", 32'(width), 32'(e.w));
            chk("nominal", 32'(nominal), 32'(e.n));
            chk("state_at_valid", 32'(state), 2);
            chk("err_at_valid", 32'(err_long), 0);
         end
      end
      prev_v <= (valid === 1'b1);
   end

   task automatic tick_once();
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic push(logic [3:0] w, logic n);
      exp_t e;
      e.w = w;
      e.n = n;
      sb.push_back(e);
   endtask

   task automatic pulse(int n, logic [3:0] ew, logic en, bit clr_rep);
      din = 1'b1;
      repeat (n) tick_once();
      din = 1'b0;
      push(ew, en);
      tick_once();
`ifdef PULSE_STATS_EN
      if (clr_rep) begin
         clr_stats = 1'b1;
         @(negedge clk);
         clr_stats = 1'b0;
      end
`endif
      tick_once();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      tick  = 1'b0;
      din   = 1'b0;
`ifdef PULSE_STATS_EN
      clr_stats = 1'b0;
`endif
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_state", 32'(state), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_width", 32'(width), 0);
      chk("rst_nominal", 32'(nominal), 0);
      chk("rst_err", 32'(err_long), 0);
      for (int i = 0; i < 20; i++) begin
         tick_once();
         chk("idle_state", 32'(state), 0);
         chk("idle_err", 32'(err_long), 0);
      end

      // nominal 3-tick pulse with state walk
      din = 1'b1;
      tick_once();
      chk("t2_state_meas", 32'(state), 1);
      tick_once();
      tick_once();
      din = 1'b0;
      push(4'd3, 1'b1);
      tick_once();
      chk("t2_state_rep", 32'(state), 2);
      chk("t2_valid", 32'(valid), 1);
      @(negedge clk);
      chk("t2_state_idle", 32'(state), 0);
      chk("t2_valid_low", 32'(valid), 0);
      tick_once();

      // 1-tick and 5-tick pulses
      pulse(1, 4'd1, 1'b0, 1'b0);
      pulse(5, 4'd5, 1'b0, 1'b0);
      repeat (3) tick_once();
      chk("t3_width_hold", 32'(width), 5);
      chk("t3_nominal_hold", 32'(nominal), 0);

      // overlong pulse
      din = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick_once();
         if (i < 16) begin
            chk("t4_err_low", 32'(err_long), 0);
            chk("t4_state_meas", 32'(state), 1);
         end else begin
            chk("t4_err_high", 32'(err_long), 1);
            chk("t4_state_stuck", 32'(state), 3);
         end
      end
      din = 1'b0;
      tick_once();
      chk("t4_err_clear", 32'(err_long), 0);
      chk("t4_state_idle", 32'(state), 0);
      chk("t4_width_kept", 32'(width), 5);
      tick_once();

      // reset during a pulse
      din = 1'b1;
      tick_once();
      repeat (3) @(negedge clk);
      tick  = 1'b1;
      reset = 1'b1;
      din   = 1'b0;
      #1;
      chk("t5_state", 32'(state), 0);
      chk("t5_width", 32'(width), 0);
      chk("t5_err", 32'(err_long), 0);
      chk("t5_valid", 32'(valid), 0);
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (4) tick_once();
      chk("t5_idle_after", 32'(state), 0);
      pulse(3, 4'd3, 1'b1, 1'b0);
      pulse(2, 4'd2, 1'b0, 1'b0);

`ifdef PULSE_STATS_EN
      clr_stats = 1'b1;
      @(negedge clk);
      clr_stats = 1'b0;
      chk("t6_cleared", 32'(nom_cnt), 0);
      pulse(3, 4'd3, 1'b1, 1'b0);
      pulse(3, 4'd3, 1'b1, 1'b0);
      pulse(2, 4'd2, 1'b0, 1'b0);
      pulse(3, 4'd3, 1'b1, 1'b0);
      chk("t6_nom_cnt", 32'(nom_cnt), 3);
      pulse(3, 4'd3, 1'b1, 1'b1);
      chk("t6_clr_wins", 32'(nom_cnt), 0);
`endif

      repeat (4) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
